result_streamer: RTL and testbench

Drains the 16-entry 4x4 result memory (output_memory) of the systolic array after a matrix product has been written. It sequences read addresses 0..15 over the memory's read/addrO/dataO port and absorbs the 1-cycle read latency. It presents the results as an in-order valid/ready stream with a last marker. It sits directly downstream of output_memory and feeds the host/DMA side.

---
 rtl/result_streamer_pkg.sv | 27 ++
 rtl/result_streamer_if.sv | 29 ++
 rtl/result_streamer_stream_fifo.sv | 68 ++++++
 rtl/result_streamer.sv | 126 ++++++++++++
 tb/tb_result_streamer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/result_streamer_pkg.sv
// Purpose: shared constants and types for the result streamer and its FIFO.
//   DATA_W     - width of one result word
//   DEPTH      - result words per 4x4 matrix
//   ADDR_W     - result memory address width
//   FIFO_DEPTH - skid FIFO entries; 3 sustains one word per cycle while
//                mem_read depends only on registered state
package result_streamer_pkg;

  localparam int DATA_W     = 32;
  localparam int DEPTH      = 16;
  localparam int ADDR_W     = 4;
  localparam int FIFO_DEPTH = 3;
  localparam int CNT_W      = 2;   // holds 0..FIFO_DEPTH

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/result_streamer_if.sv
// Purpose: groups the result-memory read port and the outgoing result stream.
//   mem_read/mem_addr  - read request to output_memory
//   mem_data           - read data, valid one cycle after mem_read
//   out_valid/out_ready- stream handshake
//   out_data/out_index/out_last - stream payload
// master: the streamer side. slave: memory + downstream consumer side.
interface result_streamer_if;
  import result_streamer_pkg::*;

  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output mem_read, mem_addr, out_valid, out_data, out_index, out_last,
    input  mem_data, out_ready
  );

  modport slave (
    input  mem_read, mem_addr, out_valid, out_data, out_index, out_last,
    output mem_data, out_ready
  );

endinterface

// File: rtl/result_streamer_stream_fifo.sv
// Purpose: small synchronous FIFO of {last, index, data} beats.
//   clk, rst  - clock, asynchronous active-high reset (flushes, zeroes storage)
//   i_push    - write i_data (ignored when full unless popping the same cycle)
//   i_pop     - remove head (ignored when empty)
//   o_head    - current head entry (all zero after reset)
//   o_empty   - no entries held
//   o_count   - number of entries held
module stream_fifo
  import result_streamer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  beat_t            i_data,
  input  logic             i_pop,
  output beat_t            o_head,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  beat_t            r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Pointer advance with wrap at the (non power of two) depth.
  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == CNT_W'(FIFO_DEPTH - 1)) ? CNT_W'(0) : p + CNT_W'(1);
  endfunction

  // Qualify push/pop against occupancy.
  always_comb begin
    w_pop_ok  = i_pop && (r_count != CNT_W'(0));
    w_push_ok = i_push && ((r_count != CNT_W'(FIFO_DEPTH)) || w_pop_ok);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= CNT_W'(0);
      r_rd_ptr <= CNT_W'(0);
      r_count  <= CNT_W'(0);
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == CNT_W'(0));
  assign o_count = r_count;

endmodule

// File: rtl/result_streamer.sv
// Purpose: reads the 16 result words of a finished matrix product from
// output_memory in address order and presents them as a valid/ready stream
// with a last marker on address DEPTH-1.
//   clk, rst  - clock, asynchronous active-high reset
//   i_start   - stream one matrix; only honoured while idle
//   o_busy    - a stream is in progress
//   o_done    - one-cycle pulse after the last beat is accepted
//   bus       - memory read port and output stream (master side)
module result_streamer
  import result_streamer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  result_streamer_if.master   bus
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_cap_idx;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_room;
  logic              w_issue;
  logic              w_pop;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  beat_t             w_head;
  beat_t             w_push_beat;

  stream_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_inflight),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Issue control and next-state logic. A read is only issued when the word
  // it returns is guaranteed a FIFO slot, counting the word still in flight,
  // so out_ready never reaches mem_read combinationally.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_room      = ({1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight}) < (CNT_W + 1)'(FIFO_DEPTH);
    w_issue     = 1'b0;
    w_pop       = (!w_empty) && bus.out_ready;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_nxt = READ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      READ: begin
        w_issue = w_room;
        if (w_issue && (r_rd_ptr == ADDR_W'(DEPTH - 1))) begin
          w_state_nxt = DRAIN;
        end else begin
          w_state_nxt = READ;
        end
      end
      DRAIN: begin
        if (w_pop && w_head.last) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, read pointer, in-flight tracking and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rd_ptr   <= ADDR_W'(0);
      r_inflight <= 1'b0;
      r_cap_idx  <= ADDR_W'(0);
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_done     <= w_done_nxt;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_cap_idx <= r_rd_ptr;
      end
      // The pointer parks on the last address instead of wrapping; the next
      // accepted start rewinds it.
      if ((r_state == IDLE) && i_start) begin
        r_rd_ptr <= ADDR_W'(0);
      end else if (w_issue && (r_rd_ptr != ADDR_W'(DEPTH - 1))) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Word returned by last cycle's read, tagged with its address.
  always_comb begin
    w_push_beat.data  = bus.mem_data;
    w_push_beat.index = r_cap_idx;
    w_push_beat.last  = (r_cap_idx == ADDR_W'(DEPTH - 1));
  end

  assign bus.mem_read  = w_issue;
  assign bus.mem_addr  = r_rd_ptr;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head.data;
  assign bus.out_index = w_head.index;
  assign bus.out_last  = w_head.last;
  assign o_busy        = (r_state != IDLE);
  assign o_done        = r_done;

endmodule

// File: tb/tb_result_streamer.sv
module tb_result_streamer;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  result_streamer_if bus();

  result_streamer dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency.
  logic [31:0] mem [16];
  int cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_read) bus.mem_data <= mem[bus.mem_addr];
  end

  // Stream recorder and occupancy scoreboard.
  logic [31:0] bw [512];
  logic [3:0]  bi [512];
  logic        bl [512];
  int          bc [512];
  int nbeats = 0, ndone = 0, last_done_cyc = 0;
  int issued = 0, accepted = 0, max_occ = 0, hold_err = 0;
  logic prev_stall = 1'b0;
  logic [31:0] pd;
  logic [3:0]  pi;
  logic        pl;

  always @(negedge clk) begin
    if (rst) begin
      issued = 0; accepted = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(bus.out_valid === 1'b1 && bus.out_data === pd &&
                          bus.out_index === pi && bus.out_last === pl)) hold_err++;
      prev_stall = bus.out_valid && !bus.out_ready;
      pd = bus.out_data; pi = bus.out_index; pl = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        bw[nbeats % 512] = bus.out_data;
        bi[nbeats % 512] = bus.out_index;
        bl[nbeats % 512] = bus.out_last;
        bc[nbeats % 512] = cyc;
        nbeats++; accepted++;
      end
      if (bus.mem_read) issued++;
      if (done) begin ndone++; last_done_cyc = cyc; end
      if (issued - accepted > max_occ) max_occ = issued - accepted;
    end
  end

  int n_cmp = 0, n_fail = 0;

  task automatic start_pulse(output int c0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c0 = cyc;
  endtask

  task automatic test_reset;
    #12;
    n_cmp++;
    if ({busy, done, bus.mem_read, bus.mem_addr, bus.out_valid, bus.out_index, bus.out_last} !== 11'd0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 0", {busy, done, bus.mem_read, bus.mem_addr, bus.out_valid, bus.out_index, bus.out_last});
    end
    n_cmp++;
    if (bus.out_data !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    @(posedge clk); #3 rst = 1'b0;
  endtask

  task automatic test_basic;
    int c0, b0, d0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
    bus.out_ready = 1'b1; b0 = nbeats; d0 = ndone;
    start_pulse(c0);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b want 1", busy); end
    for (int k = 0; k < 60 && ndone == d0; k++) @(negedge clk);
    n_cmp++;
    if (ndone !== d0 + 1) begin n_fail++; $display("FAIL basic_done got %0d want %0d", ndone - d0, 1); end
    n_cmp++;
    if (nbeats - b0 !== 16) begin n_fail++; $display("FAIL basic_count got %0d want 16", nbeats - b0); end
    n_cmp++;
    if (last_done_cyc !== c0 + 18) begin n_fail++; $display("FAIL basic_done_time got %0d want %0d", last_done_cyc - c0, 18); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512]} !== {mem[k], 4'(k), (k == 15)}) begin
        n_fail++; $display("FAIL basic_beat%0d got %h/%0d/%b want %h/%0d/%b", k, bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512], mem[k], k, (k == 15));
      end
      n_cmp++;
      if (bc[(b0+k)%512] !== c0 + 2 + k) begin n_fail++; $display("FAIL basic_time%0d got %0d want %0d", k, bc[(b0+k)%512] - c0, 2 + k); end
    end
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b want 0", busy); end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %b want 0", done); end
  endtask

  task automatic test_backpressure;
    int c0, b0, d0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
    bus.out_ready = 1'b1; b0 = nbeats; d0 = ndone;
    start_pulse(c0);
    repeat (4) @(posedge clk);
    #1 bus.out_ready = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.out_data, bus.out_index} !== {1'b1, 32'h102, 4'd2}) begin
      n_fail++; $display("FAIL bp_hold got v=%b %h/%0d want v=1 102/2", bus.out_valid, bus.out_data, bus.out_index);
    end
    n_cmp++;
    if (bus.mem_read !== 1'b0) begin n_fail++; $display("FAIL bp_mem_read got %b want 0", bus.mem_read); end
    n_cmp++;
    if (issued - accepted !== 3) begin n_fail++; $display("FAIL bp_buffered got %0d want 3", issued - accepted); end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    for (int k = 0; k < 80 && ndone == d0; k++) @(negedge clk);
    n_cmp++;
    if (nbeats - b0 !== 16 || ndone !== d0 + 1) begin
      n_fail++; $display("FAIL bp_count got %0d beats %0d done want 16 beats 1 done", nbeats - b0, ndone - d0);
    end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512]} !== {mem[k], 4'(k), (k == 15)}) begin
        n_fail++; $display("FAIL bp_beat%0d got %h/%0d/%b want %h/%0d", k, bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512], mem[k], k);
      end
    end
    n_cmp++;
    if (hold_err !== 0) begin n_fail++; $display("FAIL bp_stable got %0d unstable stalls want 0", hold_err); end
  endtask

  task automatic test_random;
    int c0, b0, d0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      b0 = nbeats; d0 = ndone;
      start_pulse(c0);
      for (int k = 0; k < 400 && ndone == d0; k++) begin
        @(posedge clk); #1 bus.out_ready = 1'($urandom_range(0, 1));
      end
      bus.out_ready = 1'b1;
      repeat (6) @(negedge clk);
      n_cmp++;
      if (nbeats - b0 !== 16 || ndone !== d0 + 1) begin
        n_fail++; $display("FAIL rand%0d_count got %0d beats %0d done want 16 beats 1 done", r, nbeats - b0, ndone - d0);
      end
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if ({bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512]} !== {mem[k], 4'(k), (k == 15)}) begin
          n_fail++; $display("FAIL rand%0d_beat%0d got %h/%0d/%b want %h/%0d", r, k, bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512], mem[k], k);
        end
      end
    end
    n_cmp++;
    if (max_occ > 3) begin n_fail++; $display("FAIL occupancy got %0d want <=3", max_occ); end
    n_cmp++;
    if (hold_err !== 0) begin n_fail++; $display("FAIL rand_stable got %0d unstable stalls want 0", hold_err); end
  endtask

  task automatic test_back_to_back;
    int c0, b0, d0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
    bus.out_ready = 1'b1; b0 = nbeats; d0 = ndone;
    start_pulse(c0);
    // starts sampled mid-READ (beat 3) and at the last-beat edge are ignored;
    // the one sampled the edge after done begins a second stream
    for (int k = 0; k < 80 && ndone < d0 + 2; k++) begin
      @(posedge clk); #1 start = (cyc == c0 + 5) || (cyc == c0 + 17) || (cyc == c0 + 18);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (nbeats - b0 !== 32 || ndone !== d0 + 2) begin
      n_fail++; $display("FAIL b2b_count got %0d beats %0d done want 32 beats 2 done", nbeats - b0, ndone - d0);
    end
    for (int k = 0; k < 32; k++) begin
      n_cmp++;
      if ({bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512]} !== {mem[k%16], 4'(k % 16), (k % 16 == 15)}) begin
        n_fail++; $display("FAIL b2b_beat%0d got %h/%0d/%b want %h/%0d", k, bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512], mem[k%16], k % 16);
      end
    end
    n_cmp++;
    if (bc[(b0+16)%512] !== c0 + 21) begin n_fail++; $display("FAIL b2b_second_start got %0d want %0d", bc[(b0+16)%512] - c0, 21); end
  endtask

  task automatic test_async_reset;
    int c0, b0, d0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + i;
    bus.out_ready = 1'b1;
    start_pulse(c0);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, bus.mem_read, bus.mem_addr, bus.out_valid, bus.out_index, bus.out_last} !== 11'd0) begin
      n_fail++; $display("FAIL arst_ctrl got %b want 0", {busy, done, bus.mem_read, bus.mem_addr, bus.out_valid, bus.out_index, bus.out_last});
    end
    n_cmp++;
    if (bus.out_data !== 32'd0) begin n_fail++; $display("FAIL arst_data got %h want 0", bus.out_data); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    b0 = nbeats; d0 = ndone;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_resume got %b want 0", bus.out_valid); end
    start_pulse(c0);
    for (int k = 0; k < 60 && ndone == d0; k++) @(negedge clk);
    n_cmp++;
    if (nbeats - b0 !== 16 || ndone !== d0 + 1) begin
      n_fail++; $display("FAIL arst_count got %0d beats %0d done want 16 beats 1 done", nbeats - b0, ndone - d0);
    end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512]} !== {mem[k], 4'(k), (k == 15)}) begin
        n_fail++; $display("FAIL arst_beat%0d got %h/%0d/%b want %h/%0d", k, bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512], mem[k], k);
      end
    end
  endtask

  task automatic test_wide_data;
    int c0, b0, d0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0000; mem[15] = 32'hFFFF_FFFF;
    mem[3] = 32'hFFFF_FFFF; mem[9] = 32'h8000_0001;
    bus.out_ready = 1'b1; b0 = nbeats; d0 = ndone;
    start_pulse(c0);
    for (int k = 0; k < 60 && ndone == d0; k++) @(negedge clk);
    n_cmp++;
    if (nbeats - b0 !== 16) begin n_fail++; $display("FAIL wide_count got %0d want 16", nbeats - b0); end
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if ({bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512]} !== {mem[k], 4'(k), (k == 15)}) begin
        n_fail++; $display("FAIL wide_beat%0d got %h/%0d/%b want %h/%0d/%b", k, bw[(b0+k)%512], bi[(b0+k)%512], bl[(b0+k)%512], mem[k], k, (k == 15));
      end
    end
  endtask

  int seed_val;

  initial begin
    seed_val = $urandom(32'd2024);
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_wide_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
